// File: rtl/alu593_exec_unit.sv
// ALU593 execution unit: accepts one op per start while idle and returns a 16-bit result with a done pulse.
// Latency is 1 cycle, or 9 for mul and 10 for sp_func1 (iterative shift-add); start while busy is dropped.
module alu593_exec_unit #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  result,
    output logic              err
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_SPF1  = 4'd5;
    localparam logic [3:0] OP_SPF2  = 4'd6;
    localparam logic [3:0] OP_SPF3  = 4'd7;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_NOP1  = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_MULT, S_ACCUM} state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [DATA_W-1:0]  a_q, b_q, stor_q, mplier_q;
    logic [RES_W-1:0]   mcand_q, prod_q, result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q, err_q;

    logic [RES_W-1:0]   exec_res_d;
    logic               exec_err_d, exec_keep_d;
    logic [RES_W-1:0]   a_ext, b_ext;

    assign a_ext = RES_W'(a_q);
    assign b_ext = RES_W'(b_q);

    // Single-cycle ops; subtraction wraps at RES_W so a borrow sign-extends naturally.
    always_comb begin
        exec_res_d  = '0;
        exec_err_d  = 1'b0;
        exec_keep_d = 1'b0;
        case (op_q)
            OP_NOP, OP_NOP1: exec_keep_d = 1'b1;
            OP_ADD:          exec_res_d  = a_ext + b_ext;
            OP_AND:          exec_res_d  = a_ext & b_ext;
            OP_XOR:          exec_res_d  = a_ext ^ b_ext;
            OP_SPF2:         exec_res_d  = a_ext - b_ext;
            OP_SPF3:         exec_res_d  = {b_q, a_q};
            OP_LOAD:         exec_res_d  = RES_W'(stor_q);
            OP_STORE:        exec_res_d  = a_ext;
            default:         exec_err_d  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            stor_q   <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_q    <= A;
                        b_q    <= B;
                        busy_q <= 1'b1;
                        if (op == OP_MUL || op == OP_SPF1) begin
                            state_q  <= S_MULT;
                            mcand_q  <= RES_W'(A);
                            mplier_q <= B;
                            prod_q   <= '0;
                            cnt_q    <= '0;
                        end else begin
                            state_q <= S_EXEC1;
                        end
                    end
                end
                S_EXEC1: begin
                    done_q  <= 1'b1;
                    err_q   <= exec_err_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (!exec_keep_d) result_q <= exec_res_d;
                    if (op_q == OP_STORE) stor_q <= a_q;
                end
                S_MULT: begin
                    // One multiplier bit per cycle, then one extra cycle to publish or accumulate.
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        if (op_q == OP_MUL) begin
                            result_q <= prod_q;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end else begin
                        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                S_ACCUM: begin
                    result_q <= prod_q + RES_W'(stor_q);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
endmodule
